// File: rtl/ifetch_unit.sv
// PC register and instruction-fetch stage: FETCH/HOLD handshake with stall, flush and retire counter.
// Optional misaligned-fetch check is enabled by defining IFETCH_ALIGN_CHK_EN.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_next,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_cur,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic [31:0] retire_cnt
`ifdef IFETCH_ALIGN_CHK_EN
    ,
    output logic        adel_exc
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_d;
    logic        load_pc;
    logic        consume;
    logic        take_rsp;

    // NOTE: every signal driven in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_cur;
        load_pc  = 1'b0;
        consume  = 1'b0;
        take_rsp = 1'b0;
        if (flush) begin
            // A redirect wins over both the memory response and consumption.
            pc_d    = flush_pc;
            load_pc = 1'b1;
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        take_rsp = 1'b1;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_d    = pc_next;
                        load_pc = 1'b1;
                        consume = 1'b1;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
`ifdef IFETCH_ALIGN_CHK_EN
        // A misaligned PC never reaches memory; it becomes a faulting entry directly.
        if (load_pc && (pc_d[1:0] != 2'b00)) begin
            state_d = HOLD;
        end
`endif
    end

    assign imem_req  = (state_q == FETCH);
    assign ins_valid = (state_q == HOLD);
`ifdef IFETCH_ALIGN_CHK_EN
    assign imem_addr = pc_cur;
    localparam state_t RESET_STATE = (RESET_PC[1:0] != 2'b00) ? HOLD : FETCH;
`else
    assign imem_addr = {pc_cur[31:2], 2'b00};
    localparam state_t RESET_STATE = FETCH;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_cur     <= RESET_PC;
            ins        <= 32'h0000_0000;
            retire_cnt <= 32'h0000_0000;
        end else begin
            pc_cur <= pc_d;
            if (take_rsp) begin
                ins <= imem_rdata;
            end
            if (consume) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
`ifdef IFETCH_ALIGN_CHK_EN
            if (load_pc && (pc_d[1:0] != 2'b00)) begin
                ins <= 32'h0000_0000;
            end
`endif
        end
    end

`ifdef IFETCH_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adel_exc <= (RESET_PC[1:0] != 2'b00);
        end else if (load_pc) begin
            adel_exc <= (pc_d[1:0] != 2'b00);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit; the misalignment scenario runs when IFETCH_ALIGN_CHK_EN is defined.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_next;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc_cur;
    logic [31:0] ins;
    logic        ins_valid;
    logic [31:0] retire_cnt;
`ifdef IFETCH_ALIGN_CHK_EN
    logic        adel_exc;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_next    (pc_next),
        .stall      (stall),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc_cur     (pc_cur),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .retire_cnt (retire_cnt)
`ifdef IFETCH_ALIGN_CHK_EN
        ,
        .adel_exc   (adel_exc)
`endif
    );

    // Advance one rising edge and settle; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_next = '0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
        imem_rdata = 32'hFFFF_FFFF; imem_ready = 1'b1;
        step(); step();
        imem_ready = 1'b0;
        cmp("reset_pc", pc_cur, 32'h0000_3000);
        cmp("reset_ins", ins, 32'h0);
        cmp("reset_valid", {31'b0, ins_valid}, 32'h0);
        cmp("reset_retire", retire_cnt, 32'h0);
`ifdef IFETCH_ALIGN_CHK_EN
        cmp("reset_adel", {31'b0, adel_exc}, 32'h0);
`endif
        rst_n = 1'b1;
        step();
        cmp("post_reset_req", {31'b0, imem_req}, 32'h1);
        cmp("post_reset_addr", imem_addr, 32'h0000_3000);
    endtask

    task automatic test_zero_wait();
        imem_ready = 1'b1; imem_rdata = 32'h2008_0005; pc_next = 32'h0000_3004;
        step();
        imem_ready = 1'b0; imem_rdata = 32'h0;
        cmp("zw_valid", {31'b0, ins_valid}, 32'h1);
        cmp("zw_ins", ins, 32'h2008_0005);
        cmp("zw_req_hold", {31'b0, imem_req}, 32'h0);
        cmp("zw_pc_hold", pc_cur, 32'h0000_3000);
        step();
        cmp("zw_pc_next", pc_cur, 32'h0000_3004);
        cmp("zw_retire", retire_cnt, 32'h1);
        cmp("zw_valid_clr", {31'b0, ins_valid}, 32'h0);
        cmp("zw_req_again", {31'b0, imem_req}, 32'h1);
        cmp("zw_addr_again", imem_addr, 32'h0000_3004);
    endtask

    task automatic test_wait_states();
        flush = 1'b1; flush_pc = 32'h0000_3000;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmp("ws_req", {31'b0, imem_req}, 32'h1);
            cmp("ws_addr", imem_addr, 32'h0000_3000);
            cmp("ws_valid_low", {31'b0, ins_valid}, 32'h0);
            if (i == 3) begin
                imem_ready = 1'b1; imem_rdata = 32'hAAAA_0001; pc_next = 32'h0000_3004;
            end
            step();
        end
        imem_ready = 1'b0;
        cmp("ws_valid", {31'b0, ins_valid}, 32'h1);
        cmp("ws_ins", ins, 32'hAAAA_0001);
        cmp("ws_retire", retire_cnt, 32'h1);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            cmp("st_pc", pc_cur, 32'h0000_3000);
            cmp("st_ins", ins, 32'hAAAA_0001);
            cmp("st_retire", retire_cnt, 32'h1);
            cmp("st_req", {31'b0, imem_req}, 32'h0);
            cmp("st_valid", {31'b0, ins_valid}, 32'h1);
        end
        stall = 1'b0;
        step();
        cmp("st_release_pc", pc_cur, 32'h0000_3004);
        cmp("st_release_retire", retire_cnt, 32'h2);
        cmp("st_release_valid", {31'b0, ins_valid}, 32'h0);
    endtask

    task automatic test_flush_response();
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        flush = 1'b1; flush_pc = 32'h0000_4180;
        step();
        imem_ready = 1'b0; flush = 1'b0;
        cmp("fr_pc", pc_cur, 32'h0000_4180);
        cmp("fr_valid", {31'b0, ins_valid}, 32'h0);
        cmp("fr_req", {31'b0, imem_req}, 32'h1);
        cmp("fr_addr", imem_addr, 32'h0000_4180);
        cmp("fr_ins_kept", ins, 32'hAAAA_0001);
        cmp("fr_retire", retire_cnt, 32'h2);
    endtask

    task automatic test_flush_consume();
        imem_ready = 1'b1; imem_rdata = 32'h1111_2222;
        step();
        imem_ready = 1'b0;
        cmp("fc_valid", {31'b0, ins_valid}, 32'h1);
        cmp("fc_ins", ins, 32'h1111_2222);
        flush = 1'b1; flush_pc = 32'h0000_5000; pc_next = 32'h0000_4184; stall = 1'b0;
        step();
        flush = 1'b0;
        cmp("fc_pc", pc_cur, 32'h0000_5000);
        cmp("fc_retire", retire_cnt, 32'h2);
        cmp("fc_valid_clr", {31'b0, ins_valid}, 32'h0);
        cmp("fc_req", {31'b0, imem_req}, 32'h1);
    endtask

`ifdef IFETCH_ALIGN_CHK_EN
    task automatic test_misaligned();
        imem_ready = 1'b1; imem_rdata = 32'h3333_4444; pc_next = 32'h0000_3006;
        step();
        imem_ready = 1'b0;
        cmp("ma_valid", {31'b0, ins_valid}, 32'h1);
        step();
        cmp("ma_pc", pc_cur, 32'h0000_3006);
        cmp("ma_req", {31'b0, imem_req}, 32'h0);
        cmp("ma_adel", {31'b0, adel_exc}, 32'h1);
        cmp("ma_ins", ins, 32'h0);
        cmp("ma_valid_fault", {31'b0, ins_valid}, 32'h1);
        cmp("ma_retire", retire_cnt, 32'h3);
        pc_next = 32'h0000_3008;
        step();
        cmp("ma_adel_clr", {31'b0, adel_exc}, 32'h0);
        cmp("ma_retire_fault", retire_cnt, 32'h4);
        cmp("ma_req_again", {31'b0, imem_req}, 32'h1);
        cmp("ma_addr", imem_addr, 32'h0000_3008);
    endtask
`else
    task automatic test_addr_align();
        flush = 1'b1; flush_pc = 32'h0000_5006;
        step();
        flush = 1'b0;
        cmp("al_pc", pc_cur, 32'h0000_5006);
        cmp("al_addr", imem_addr, 32'h0000_5004);
        cmp("al_req", {31'b0, imem_req}, 32'h1);
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_flush_response();
        test_flush_consume();
`ifdef IFETCH_ALIGN_CHK_EN
        test_misaligned();
`else
        test_addr_align();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

PC register and instruction-fetch stage of the MIPS core. Holds the current PC and fetches the instruction at that address from instruction memory over a ready-based handshake. Presents the `pc_cur` and `ins` pair to the next-PC logic and the decoder. Loads the next-PC result into the PC when the instruction is consumed. It is a two-state sequential block with stall and redirect (flush) support and a retired-instruction counter.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_3000`: PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `pc_next`  in  32  next PC from the next-PC logic, computed from `pc_cur` and `ins`.
- `stall`  in  1  downstream hazard hold; the held instruction is not consumed.
- `flush`  in  1  redirect request; highest priority after reset.
- `flush_pc`  in  32  redirect target.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address.
- `imem_rdata`  in  32  instruction word; valid when `imem_ready` is 1.
- `imem_ready`  in  1  memory response this cycle.
- `pc_cur`  out  32  address of the instruction in `ins`.
- `ins`  out  32  fetched instruction.
- `ins_valid`  out  1  `ins` is valid for `pc_cur`.
- `retire_cnt`  out  32  count of instructions consumed.
- `adel_exc`  out  1  misaligned-fetch exception; exists only with the macro (see Configuration).

## Operation
- States:
  - FETCH: a request is outstanding for `pc_cur`.
  - HOLD: `ins` is valid and waits to be consumed.
- FETCH behaviour:
  - `imem_req`=1 and `imem_addr`=`pc_cur`, both combinational from state and PC.
  - If `imem_ready`: `ins`<=`imem_rdata`, `ins_valid`<=1, go to HOLD.
  - Otherwise stay in FETCH. The request and address are held stable.
- HOLD behaviour:
  - `imem_req`=0.
  - If `stall`=0, the instruction is consumed: `pc_cur`<=`pc_next`, `ins_valid`<=0, `retire_cnt`+=1, go to FETCH.
  - If `stall`=1, everything is held.
  - `ins` keeps its last value after consumption and is ignored while `ins_valid`=0.
- Flush, in any state: `pc_cur`<=`flush_pc`, `ins_valid`<=0, go to FETCH.
  - Any `imem_ready`/`imem_rdata` in the same cycle is discarded.
  - `retire_cnt` is not incremented, even if HOLD with `stall`=0 coincides.
- `retire_cnt` wraps from `32'hFFFF_FFFF` to 0.
- PC arithmetic is entirely upstream; this block never adds to the PC.

## Timing
- Reset, at a rising edge with `rst_n`=0:
  - `pc_cur`=`RESET_PC`, `ins`=0 (NOP), `ins_valid`=0, `retire_cnt`=0, state FETCH, `adel_exc`=0.
  - `imem_req` is 1 in the first cycle after reset deassertion.
- Reset mid-fetch abandons the outstanding request. The block does not track late `imem_ready` responses; the memory must drop its request on reset.
- Minimum throughput, zero-wait memory and no stall: 2 cycles per instruction.
  - Cycle N: FETCH with `imem_ready`=1.
  - Cycle N+1: HOLD, instruction consumed.
- Each extra memory wait cycle adds one cycle. Each `stall` cycle in HOLD adds one cycle.
- `pc_next` is sampled only on the consuming edge, so it must be settled combinationally from `pc_cur`/`ins` in that cycle.
- Priority: reset > flush > consume/stall > memory response.

## Configuration
- `IFETCH_ALIGN_CHK_EN` defined:
  - The PC is checked whenever it is loaded (consume, flush, reset). If `pc_cur[1:0]`≠0, the block enters HOLD without issuing a request, with `ins`=0, `ins_valid`=1 and `adel_exc`=1.
  - `adel_exc` clears when the entry is consumed or flushed.
  - Consuming the faulting entry still increments `retire_cnt`.
- `IFETCH_ALIGN_CHK_EN` undefined:
  - `imem_addr`=`{pc_cur[31:2],2'b00}`.
  - The `adel_exc` port is absent; no check is performed.

## Test plan
- Reset, then zero-wait memory returning `32'h2008_0005` at `32'h3000`, `pc_next`=`32'h3004`, no stall:
  - `ins_valid`=1 one cycle after the response.
  - Next cycle `pc_cur`=`32'h3004` and `retire_cnt`=1.
- Memory delays `imem_ready` by 3 cycles: `imem_req`=1 and `imem_addr`=`32'h3000` are held stable for 4 cycles; `ins_valid` rises only after `imem_ready`.
- `stall`=1 for 5 cycles in HOLD: `pc_cur`, `ins` and `retire_cnt` are unchanged and `imem_req`=0; consumption occurs on the first cycle with `stall`=0.
- `flush`=1 with `flush_pc`=`32'h0000_4180` in the same cycle as `imem_ready`=1:
  - Response discarded, `pc_cur`=`32'h4180`, `ins_valid`=0.
  - The next request is to `32'h4180`.
- `flush` together with a consuming HOLD cycle: `retire_cnt` is unchanged and `pc_cur`=`flush_pc`, not `pc_next`.
- Macro on, `pc_next`=`32'h3006`: no request issued; next cycle `adel_exc`=1, `ins`=0, `ins_valid`=1.
